// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry, the baud
// divider helper and the arbiter state encoding.
package uart_pkg;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  // Whole clock cycles per bit on the line (truncating division).
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// the pointer, wrapping around, plus a flag that any request is present.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int            w_pos;
  logic [IW-1:0] w_pos_idx;

  // Scan from the farthest candidate back to the pointer so the closest set
  // bit (in wrap order) is the last one written and therefore wins.
  always_comb begin
    o_idx     = '0;
    o_any     = |i_req;
    w_pos     = 0;
    w_pos_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) begin
        w_pos = w_pos - N_REQ;
      end
      w_pos_idx = IW'(w_pos);
      if (i_req[w_pos_idx]) begin
        o_idx = w_pos_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter and byte pacer in front of a single tx_uart.
// The line is granted per message: once a requester issues a non-final byte
// it keeps the grant until its final byte, or until it stalls for HOLD_MAX
// cycles. tx_uart has no busy output, so bytes are spaced by a frame timer.
//
// Handshake: requester i raises req[i] with data/last and holds all three
// stable until it sees the one-cycle ack[i] pulse; in the cycle after ack it
// presents its next byte or drops req[i]. There is no back-pressure on the
// tx side: tx_ready is a one-cycle start strobe and tx_uart is assumed idle
// whenever it arrives, which the frame timer guarantees.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int GAP_BITS = 1,
  parameter int HOLD_MAX = 100_000,
  localparam int GW      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   last,
  input  logic [N_REQ*8-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         tx_data,
  output logic               tx_ready,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               drop
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BYTE_CYCLES  = CLKS_PER_BIT * (FRAME_BITS + GAP_BITS);
  localparam int CNT_MAX      = (BYTE_CYCLES > HOLD_MAX) ? BYTE_CYCLES : HOLD_MAX;
  localparam int CW           = $clog2(CNT_MAX + 1);

  // The counter is cleared on the edge that starts an interval, so the
  // interval ends on the edge where it holds length-1.
  localparam logic [CW-1:0] BYTE_LAST = CW'(BYTE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
  localparam logic [GW-1:0] LAST_ID   = GW'(N_REQ - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_lock;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    r_gid;
  logic [N_REQ-1:0] r_ack;
  logic [7:0]       r_tx_data;
  logic             r_tx_ready;
  logic             r_drop;

  logic [GW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [GW-1:0]    w_g;
  logic [GW-1:0]    w_g_inc;
  logic [7:0]       w_byte;
  logic             w_issue;
  logic             w_timeout;
  logic             w_cnt_clr;
  logic             w_wait_done;
  logic             w_hold_done;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (GW)
  ) u_rr_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_wait_done = (r_cnt == BYTE_LAST);
  assign w_hold_done = (r_cnt == HOLD_LAST);
  assign w_g_inc     = (w_g == LAST_ID) ? '0 : w_g + 1'b1;

  // Next state, issue/timeout decisions and the requester being served.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_g         = r_gid;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_g         = w_pick_idx;
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_wait_done) begin
          w_cnt_clr = 1'b1;
          if (!r_lock) begin
            w_state_nxt = IDLE;
          end else if (req[r_gid]) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (req[r_gid]) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end else if (w_hold_done) begin
          w_timeout   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_issue) begin
      w_cnt_clr = 1'b1;
    end
  end

  // Byte mux for the requester being served.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_g == GW'(i)) begin
        w_byte = data[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shared frame/hold timer; parked at zero while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cnt_clr || (r_state == IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Issue and timeout side effects: strobes, grant, lock and pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack      <= '0;
      r_tx_data  <= '0;
      r_tx_ready <= 1'b0;
      r_drop     <= 1'b0;
      r_gid      <= '0;
      r_lock     <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_ack      <= '0;
      r_tx_ready <= 1'b0;
      r_drop     <= 1'b0;
      if (w_issue) begin
        r_tx_data  <= w_byte;
        r_tx_ready <= 1'b1;
        r_ack[w_g] <= 1'b1;
        r_gid      <= w_g;
        r_lock     <= ~last[w_g];
        if (last[w_g]) begin
          r_ptr <= w_g_inc;
        end
      end
      if (w_timeout) begin
        r_drop <= 1'b1;
        r_lock <= 1'b0;
        r_ptr  <= w_g_inc;
      end
    end
  end

  assign ack      = r_ack;
  assign tx_data  = r_tx_data;
  assign tx_ready = r_tx_ready;
  assign busy     = (r_state != IDLE);
  assign grant_id = r_gid;
  assign drop     = r_drop;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb with 8 clocks/bit, 1 gap bit (88-cycle byte slot)
// and a 200-cycle hold limit.
`timescale 1ns/1ps
module tb_uart_tx_arb;

  localparam int N_REQ    = 2;
  localparam int CLK_FREQ = 8;
  localparam int BAUD     = 1;
  localparam int GAP_BITS = 1;
  localparam int HOLD_MAX = 200;
  localparam int BYTE_CY  = 88;   // 8 clocks/bit * (10 + 1) bit-times

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  last;
  logic [15:0] data;
  logic [1:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic [0:0]  grant_id;
  logic        drop;

  uart_tx_arb #(
    .N_REQ    (N_REQ),
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .GAP_BITS (GAP_BITS),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .last     (last),
    .data     (data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .busy     (busy),
    .grant_id (grant_id),
    .drop     (drop)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- shared state ----------------
  int         checks;
  int         errors;
  logic [8:0] exp_q[$];    // {id, byte} in expected issue order
  logic [8:0] src_q0[$];   // {last, byte} waiting at requester 0
  logic [8:0] src_q1[$];   // {last, byte} waiting at requester 1
  int         pulse_cyc[$];
  int         drop_cyc[$];
  int         busy_fall_cyc;
  int         rise_cyc0;

  typedef struct {
    int         src;
    logic [7:0] b;
    logic       lst;
    int         gap;   // expected cycles since previous issue, 0 = not checked
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || src_q0.size() != 0 || src_q1.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1'b1);
    repeat (2) tick();
  endtask

  task automatic wait_pulses(input string name, input int count, input int budget);
    int n;
    n = 0;
    while (pulse_cyc.size() < count && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1'b1);
  endtask

  task automatic check_gap(input string name, input int idx, input int exp_gap);
    if (pulse_cyc.size() > idx) begin
      check(name, pulse_cyc[idx] - pulse_cyc[idx-1], exp_gap);
    end
  endtask

  // ---------------- driver: requester model ----------------
  // Presents queued bytes, advancing one entry per ack.
  initial begin : feeder
    req  = '0;
    last = '0;
    data = '0;
    forever begin
      @(negedge clk);
      if (req[0] && ack[0] && src_q0.size() > 0) void'(src_q0.pop_front());
      if (req[1] && ack[1] && src_q1.size() > 0) void'(src_q1.pop_front());
      if (src_q0.size() > 0) begin
        if (!req[0]) rise_cyc0 = cyc;
        req[0]     = 1'b1;
        last[0]    = src_q0[0][8];
        data[7:0]  = src_q0[0][7:0];
      end else begin
        req[0]  = 1'b0;
        last[0] = 1'b0;
      end
      if (src_q1.size() > 0) begin
        req[1]     = 1'b1;
        last[1]    = src_q1[0][8];
        data[15:8] = src_q1[0][7:0];
      end else begin
        req[1]  = 1'b0;
        last[1] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic       prev_busy;
    logic [8:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      if (drop) drop_cyc.push_back(cyc);
      if (tx_ready) begin
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got id %0d byte 0x%02h expected no issue", grant_id, tx_data);
        end else begin
          e = exp_q.pop_front();
          check("issue_byte", tx_data, e[7:0]);
          check("issue_grant_id", grant_id, e[8]);
          check("issue_ack", ack, e[8] ? 2'b10 : 2'b01);
        end
      end else if (ack != 2'b00) begin
        checks++;
        errors++;
        $display("FAIL stray_ack: got ack 0x%0h expected 0x0 without tx_ready", ack);
      end
    end
  end

  // ---------------- test sequence ----------------
  task automatic run_group(input string name, input int lo, input int hi);
    int base;
    logic id;
    base = pulse_cyc.size();
    for (int i = lo; i <= hi; i++) begin
      id = (vecs[i].src == 1);
      if (id) src_q1.push_back({vecs[i].lst, vecs[i].b});
      else    src_q0.push_back({vecs[i].lst, vecs[i].b});
      exp_q.push_back({id, vecs[i].b});
    end
    wait_done(name, 1000);
    for (int i = lo + 1; i <= hi; i++) begin
      check_gap({name, "_gap"}, base + i - lo, vecs[i].gap);
    end
  endtask

  initial begin : main
    int base;
    int dbase;
    int rel;
    checks = 0;
    errors = 0;
    busy_fall_cyc = 0;
    rise_cyc0 = 0;

    // contention: 1-byte messages from both, alternating 0,1,0,1
    vecs[0] = '{0, 8'hA0, 1'b1, 0};
    vecs[1] = '{1, 8'hB0, 1'b1, BYTE_CY + 1};
    vecs[2] = '{0, 8'hA1, 1'b1, BYTE_CY + 1};
    vecs[3] = '{1, 8'hB1, 1'b1, BYTE_CY + 1};
    // single 3-byte message from requester 0
    vecs[4] = '{0, 8'h41, 1'b0, 0};
    vecs[5] = '{0, 8'h42, 1'b0, BYTE_CY};
    vecs[6] = '{0, 8'h43, 1'b1, BYTE_CY};

    // reset: asynchronous assertion clears outputs before any clock edge
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_ack", ack, 2'b00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 1'b0);
    check("rst_drop", drop, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) tick();
    check("idle_ack", ack, 2'b00);
    check("idle_tx_ready", tx_ready, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_drop", drop, 1'b0);

    // table-driven groups
    run_group("contention", 0, 3);
    base = pulse_cyc.size();
    run_group("single", 4, 6);
    if (pulse_cyc.size() >= base + 3) begin
      check("single_busy_fall", busy_fall_cyc - pulse_cyc[base+2], BYTE_CY);
    end

    // lock: requester 1 arrives during byte 2 of a 3-byte message
    base = pulse_cyc.size();
    src_q0.push_back({1'b0, 8'h61});
    src_q0.push_back({1'b0, 8'h62});
    src_q0.push_back({1'b1, 8'h63});
    exp_q.push_back({1'b0, 8'h61});
    exp_q.push_back({1'b0, 8'h62});
    exp_q.push_back({1'b0, 8'h63});
    wait_pulses("lock_second_byte", base + 2, 400);
    repeat (10) tick();
    src_q1.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b1, 8'h55});
    wait_done("lock_done", 1000);
    check_gap("lock_gap_b2", base + 1, BYTE_CY);
    check_gap("lock_gap_b3", base + 2, BYTE_CY);
    check_gap("lock_other_after_last", base + 3, BYTE_CY + 1);

    // hold timeout: requester 0 stalls after a non-final byte
    base  = pulse_cyc.size();
    dbase = drop_cyc.size();
    src_q0.push_back({1'b0, 8'h10});
    src_q1.push_back({1'b1, 8'h77});
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b1, 8'h77});
    wait_done("hold_done", 1000);
    check("hold_drop_count", drop_cyc.size() - dbase, 1);
    if (drop_cyc.size() > dbase && pulse_cyc.size() > base) begin
      check("hold_drop_time", drop_cyc[dbase] - pulse_cyc[base], BYTE_CY + HOLD_MAX);
    end
    check_gap("hold_next_issue", base + 1, BYTE_CY + HOLD_MAX + 1);

    // hold resume: requester 0 reasserts inside the hold window
    base  = pulse_cyc.size();
    dbase = drop_cyc.size();
    src_q0.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b0, 8'h20});
    wait_pulses("resume_first", base + 1, 200);
    repeat (BYTE_CY + 50) tick();
    src_q0.push_back({1'b1, 8'h21});
    exp_q.push_back({1'b0, 8'h21});
    wait_done("resume_done", 1000);
    if (pulse_cyc.size() > base + 1) begin
      check("resume_latency", pulse_cyc[base+1] - rise_cyc0, 1);
    end
    check("resume_no_drop", drop_cyc.size() - dbase, 0);

    // reset mid-WAIT: partial message abandoned, waiting requester 1 served
    base = pulse_cyc.size();
    src_q0.push_back({1'b0, 8'h30});
    src_q0.push_back({1'b0, 8'h31});
    src_q0.push_back({1'b1, 8'h32});
    exp_q.push_back({1'b0, 8'h30});
    wait_pulses("rst_mid_first", base + 1, 200);
    src_q1.push_back({1'b1, 8'h99});
    while (pulse_cyc.size() > base && cyc < pulse_cyc[base] + 40) tick();
    check("rst_mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ack", ack, 2'b00);
    check("rst_mid_tx_ready", tx_ready, 1'b0);
    check("rst_mid_grant_id", grant_id, 1'b0);
    src_q0.delete();
    req[0]  = 1'b0;
    last[0] = 1'b0;
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h99});
    repeat (3) tick();
    rst = 1'b0;
    rel = cyc;
    wait_done("rst_mid_done", 500);
    if (pulse_cyc.size() > base + 1) begin
      check("rst_mid_reissue", pulse_cyc[base+1] - rel, 1);
    end
    check("rst_mid_pulses", pulse_cyc.size() - base, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
